// File: rtl/uart_irq_servicer.sv
// Bus master that programs the UART IER, services nIRQ (ISR read, event handshake, clear write).
// Optional per-source statistics counters are built when UART_IRQ_STATS_EN is defined.
module uart_irq_servicer #(
    parameter logic [3:0]  IER_INIT    = 4'b1111,
    parameter logic [3:0]  ADDR_IER    = 4'b0101,
    parameter logic [3:0]  ADDR_ISR    = 4'b0110,
    parameter int unsigned HOLDOFF_CYC = 2
) (
    input  logic        DSP_CLK,
    input  logic        RESETn,
    input  logic        nIRQ,
    output logic        M_CEn,
    output logic        M_WEn,
    output logic [3:0]  M_ADDR,
    output logic [31:0] M_WDATA,
    input  logic [31:0] M_RDATA,
    input  logic [3:0]  CFG_IER,
    input  logic        CFG_WR,
    output logic        EVT_VALID,
    output logic [3:0]  EVT_ISR,
    input  logic        EVT_READY,
    output logic        BUSY
`ifdef UART_IRQ_STATS_EN
    ,
    input  logic        STAT_CLR,
    output logic [79:0] STAT_CNT
`endif
);

    typedef enum logic [2:0] {
        INIT_WR, WAIT_IRQ, CFG_WR_ST, RD_ISR, RD_WAIT, EVT, CLR_WR, HOLDOFF
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_CYC - 1);

    state_t     state;
    logic       cfg_pend;
    logic [3:0] cfg_val;
    logic [3:0] hold_cnt;
    logic [3:0] rd_nib;
    logic       unused_rdata;

    assign rd_nib       = M_RDATA[3:0];
    assign unused_rdata = ^M_RDATA[31:4];

    // Bus outputs for a state are registered on the edge that enters it, so a read
    // issued on entry to RD_ISR returns data during RD_WAIT. INIT_WR is the exception:
    // reset forces the bus idle, so its write is launched on the edge that leaves it.
    always_ff @(posedge DSP_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= INIT_WR;
            M_CEn     <= 1'b1;
            M_WEn     <= 1'b1;
            M_ADDR    <= '0;
            M_WDATA   <= '0;
            EVT_VALID <= 1'b0;
            EVT_ISR   <= '0;
            BUSY      <= 1'b1;
            cfg_pend  <= 1'b0;
            cfg_val   <= '0;
            hold_cnt  <= '0;
        end else begin
            // NOTE: the idle bus is the default every cycle; later non-blocking writes in
            // this block override it, so each bus cycle lasts exactly one clock.
            M_CEn   <= 1'b1;
            M_WEn   <= 1'b1;
            M_ADDR  <= '0;
            M_WDATA <= '0;

            if (CFG_WR) begin
                cfg_pend <= 1'b1;
                cfg_val  <= CFG_IER;
            end

            case (state)
                INIT_WR: begin
                    M_CEn   <= 1'b0;
                    M_WEn   <= 1'b0;
                    M_ADDR  <= ADDR_IER;
                    M_WDATA <= {28'd0, IER_INIT};
                    BUSY    <= 1'b0;
                    state   <= WAIT_IRQ;
                end
                WAIT_IRQ: begin
                    if (cfg_pend) begin
                        M_CEn   <= 1'b0;
                        M_WEn   <= 1'b0;
                        M_ADDR  <= ADDR_IER;
                        M_WDATA <= {28'd0, cfg_val};
                        // A fresh request in this same cycle keeps the flag for another pass.
                        if (!CFG_WR) cfg_pend <= 1'b0;
                        BUSY    <= 1'b1;
                        state   <= CFG_WR_ST;
                    end else if (!nIRQ) begin
                        M_CEn  <= 1'b0;
                        M_ADDR <= ADDR_ISR;
                        BUSY   <= 1'b1;
                        state  <= RD_ISR;
                    end
                end
                CFG_WR_ST: begin
                    BUSY  <= 1'b0;
                    state <= WAIT_IRQ;
                end
                RD_ISR: state <= RD_WAIT;
                RD_WAIT: begin
                    EVT_ISR <= rd_nib;
                    if (rd_nib != 4'd0) begin
                        EVT_VALID <= 1'b1;
                        state     <= EVT;
                    end else begin
                        // Spurious interrupt: a zero clear write still releases nIRQ.
                        M_CEn  <= 1'b0;
                        M_WEn  <= 1'b0;
                        M_ADDR <= ADDR_ISR;
                        state  <= CLR_WR;
                    end
                end
                EVT: begin
                    if (EVT_READY) begin
                        EVT_VALID <= 1'b0;
                        M_CEn     <= 1'b0;
                        M_WEn     <= 1'b0;
                        M_ADDR    <= ADDR_ISR;
                        M_WDATA   <= {28'd0, EVT_ISR};
                        state     <= CLR_WR;
                    end
                end
                CLR_WR: begin
                    hold_cnt <= HOLD_LOAD;
                    state    <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (hold_cnt == 4'd0) begin
                        BUSY  <= 1'b0;
                        state <= WAIT_IRQ;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: state <= INIT_WR;
            endcase
        end
    end

`ifdef UART_IRQ_STATS_EN
    // Counter order {spurious, tx, rx, timeout, err}; index 4 counts zero reads.
    logic [4:0][15:0] stat_q;
    logic [4:0]       stat_hit;

    assign stat_hit = {rd_nib == 4'd0, rd_nib};
    assign STAT_CNT = stat_q;

    always_ff @(posedge DSP_CLK or negedge RESETn) begin
        if (!RESETn) begin
            stat_q <= '0;
        end else if (STAT_CLR) begin
            stat_q <= '0;
        end else if (state == RD_WAIT) begin
            for (int i = 0; i < 5; i++) begin
                if (stat_hit[i] && stat_q[i] != 16'hFFFF) stat_q[i] <= stat_q[i] + 16'd1;
            end
        end
    end
`endif

endmodule
